// File: rtl/npc_pkg.sv
// Shared encodings and helpers for the next-PC generator.
package npc_pkg;

  // npc_op_i encodings; all other codes hold the PC.
  localparam logic [2:0] NPC_PC4 = 3'b000;
  localparam logic [2:0] NPC_ADD = 3'b001;
  localparam logic [2:0] NPC_ALU = 3'b010;
  localparam logic [2:0] NPC_RET = 3'b011;

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } npc_state_e;

  // Low PC bits that must be zero for a legal fetch target.
  function automatic logic [1:0] align_mask(input bit c_ext);
    return c_ext ? 2'b01 : 2'b11;
  endfunction

endpackage

// File: rtl/npc_target.sv
// Redirect target selection and alignment check (combinational).
module npc_target
  import npc_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter bit          C_EXT = 1'b0
) (
  input  logic [2:0]      npc_op_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] aluc_i,
  input  logic [XLEN-1:0] epc_i,
  output logic            redirect_o,
  output logic [XLEN-1:0] target_o,
  output logic            misalign_o
);

  // Decode the redirect source; PC4 and HOLD codes are not redirects.
  always_comb begin
    redirect_o = 1'b0;
    target_o   = '0;
    case (npc_op_i)
      NPC_ADD: begin
        redirect_o = 1'b1;
        target_o   = ex_pc_i + imm_i;
      end
      NPC_ALU: begin
        redirect_o = 1'b1;
        target_o   = {aluc_i[XLEN-1:1], 1'b0};
      end
      NPC_RET: begin
        redirect_o = 1'b1;
        target_o   = epc_i;
      end
      default: ;
    endcase
  end

  assign misalign_o = redirect_o & (|(target_o[1:0] & align_mask(C_EXT)));

endmodule

// File: rtl/pc_gen.sv
// Fetch PC register with boot/run/halt control, redirect priority and
// misaligned-target reporting.
module pc_gen
  import npc_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter bit              C_EXT    = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic [2:0]      npc_op_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] aluc_i,
  input  logic [XLEN-1:0] epc_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_vec_i,
  input  logic            halt_i,
  input  logic            resume_i,
  input  logic            wb_pc_sel_i,
  input  logic            insn_len2_i,
  output logic [XLEN-1:0] pc_o,
  output logic            fetch_valid_o,
  output logic            halted_o,
  output logic [XLEN-1:0] wb_pc_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] misalign_addr_o
);

  npc_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            mis_q, mis_d;
  logic [XLEN-1:0] mis_addr_q, mis_addr_d;

  logic            redirect;
  logic [XLEN-1:0] target;
  logic            target_mis;

  npc_target #(
    .XLEN  (XLEN),
    .C_EXT (C_EXT)
  ) u_target (
    .npc_op_i   (npc_op_i),
    .ex_pc_i    (ex_pc_i),
    .imm_i      (imm_i),
    .aluc_i     (aluc_i),
    .epc_i      (epc_i),
    .redirect_o (redirect),
    .target_o   (target),
    .misalign_o (target_mis)
  );

  // Next state, next PC and misalign capture; trap > halt > redirect > PC4.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mis_d      = 1'b0;
    mis_addr_d = mis_addr_q;
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (trap_i) begin
          pc_d = trap_vec_i;
        end else if (halt_i) begin
          state_d = ST_HALT;
        end else if (redirect) begin
          // Redirects ignore stall; a bad target leaves the PC for the trap.
          if (target_mis) begin
            mis_d      = 1'b1;
            mis_addr_d = target;
          end else begin
            pc_d = target;
          end
        end else if (npc_op_i == NPC_PC4 && !stall_i) begin
          pc_d = pc_q + XLEN'(4);
        end
      end
      ST_HALT: begin
        if (trap_i) begin
          pc_d    = trap_vec_i;
          state_d = ST_RUN;
        end else if (resume_i) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // State and PC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      mis_q      <= 1'b0;
      mis_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mis_q      <= mis_d;
      mis_addr_q <= mis_addr_d;
    end
  end

  // Link/writeback PC, independent of FSM state.
  always_comb begin
    if (wb_pc_sel_i) begin
      wb_pc_o = ex_pc_i + imm_i;
    end else begin
      wb_pc_o = ex_pc_i + ((C_EXT && insn_len2_i) ? XLEN'(2) : XLEN'(4));
    end
  end

  assign pc_o            = pc_q;
  assign fetch_valid_o   = (state_q == ST_RUN);
  assign halted_o        = (state_q == ST_HALT);
  assign misalign_o      = mis_q;
  assign misalign_addr_o = mis_addr_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: one instance per C_EXT setting on shared inputs.
module tb_pc_gen;

  localparam logic [31:0] RstPc = 32'h8000_0000;
  localparam logic [2:0]  OpPc4 = 3'b000;
  localparam logic [2:0]  OpAdd = 3'b001;
  localparam logic [2:0]  OpAlu = 3'b010;
  localparam logic [2:0]  OpRet = 3'b011;
  localparam logic [2:0]  OpHold = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i, trap_i, halt_i, resume_i, wb_pc_sel_i, insn_len2_i;
  logic [2:0]  npc_op_i;
  logic [31:0] ex_pc_i, imm_i, aluc_i, epc_i, trap_vec_i;

  logic [31:0] pc0, wb0, maddr0, pc1, wb1, maddr1;
  logic        fv0, h0, mis0, fv1, h1, mis1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_gen #(.XLEN(32), .RESET_PC(RstPc), .C_EXT(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .npc_op_i(npc_op_i), .ex_pc_i(ex_pc_i),
    .imm_i(imm_i), .aluc_i(aluc_i), .epc_i(epc_i), .trap_i(trap_i), .trap_vec_i(trap_vec_i),
    .halt_i(halt_i), .resume_i(resume_i), .wb_pc_sel_i(wb_pc_sel_i),
    .insn_len2_i(insn_len2_i), .pc_o(pc0), .fetch_valid_o(fv0), .halted_o(h0),
    .wb_pc_o(wb0), .misalign_o(mis0), .misalign_addr_o(maddr0)
  );

  pc_gen #(.XLEN(32), .RESET_PC(RstPc), .C_EXT(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .npc_op_i(npc_op_i), .ex_pc_i(ex_pc_i),
    .imm_i(imm_i), .aluc_i(aluc_i), .epc_i(epc_i), .trap_i(trap_i), .trap_vec_i(trap_vec_i),
    .halt_i(halt_i), .resume_i(resume_i), .wb_pc_sel_i(wb_pc_sel_i),
    .insn_len2_i(insn_len2_i), .pc_o(pc1), .fetch_valid_o(fv1), .halted_o(h1),
    .wb_pc_o(wb1), .misalign_o(mis1), .misalign_addr_o(maddr1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall_i = 0; trap_i = 0; halt_i = 0; resume_i = 0;
    wb_pc_sel_i = 0; insn_len2_i = 0; npc_op_i = OpPc4;
    ex_pc_i = '0; imm_i = '0; aluc_i = '0; epc_i = '0; trap_vec_i = '0;
    step(); step();
    check("rst_pc0", pc0, RstPc);
    check("rst_pc1", pc1, RstPc);
    check("rst_fv", {30'd0, fv0, fv1}, 32'd0);
    check("rst_halt", {30'd0, h0, h1}, 32'd0);
    check("rst_mis", {30'd0, mis0, mis1}, 32'd0);
    check("rst_maddr", maddr0 | maddr1, 32'd0);

    // Boot: one cycle without fetch, then sequential from RESET_PC.
    rst_n = 1'b1;
    check("boot_fv", {31'd0, fv0}, 32'd0);
    step();
    check("run_fv", {30'd0, fv0, fv1}, 32'd3);
    check("run_pc", pc0, RstPc);
    step();
    check("pc4", pc0, 32'h8000_0004);
    check("pc4_c", pc1, 32'h8000_0004);

    // Stall holds PC4; a redirect beats the stall.
    stall_i = 1;
    step();
    check("stall", pc0, 32'h8000_0004);
    npc_op_i = OpAdd; ex_pc_i = 32'h100; imm_i = 32'h20;
    step();
    check("add_stall", pc0, 32'h120);
    check("add_stall_c", pc1, 32'h120);

    // jalr to 0x203 -> 0x202: misaligned only without compressed.
    stall_i = 0; npc_op_i = OpAlu; aluc_i = 32'h203;
    step();
    check("alu_hold", pc0, 32'h120);
    check("alu_mis", {31'd0, mis0}, 32'd1);
    check("alu_maddr", maddr0, 32'h202);
    check("alu_c_pc", pc1, 32'h202);
    check("alu_c_mis", {31'd0, mis1}, 32'd0);
    npc_op_i = OpHold;
    step();
    check("mis_pulse", {31'd0, mis0}, 32'd0);
    check("maddr_keep", maddr0, 32'h202);
    check("hold_pc", pc0, 32'h120);

    // Trap beats halt and redirect.
    trap_i = 1; halt_i = 1; npc_op_i = OpAdd; trap_vec_i = 32'h40;
    step();
    check("trap_pc0", pc0, 32'h40);
    check("trap_pc1", pc1, 32'h40);
    check("trap_run", {30'd0, fv0, h0}, 32'd2);

    // Halt, ignore PC4 while halted, resume at the same PC.
    trap_i = 0; halt_i = 1; npc_op_i = OpHold;
    step();
    check("halt", {30'd0, fv0, h0}, 32'd1);
    check("halt_pc", pc0, 32'h40);
    halt_i = 0; npc_op_i = OpPc4;
    step();
    check("halt_frz", pc0, 32'h40);
    resume_i = 1;
    step();
    check("resume", {30'd0, fv0, h0}, 32'd2);
    check("resume_pc", pc0, 32'h40);
    resume_i = 0;
    step();
    check("resume_pc4", pc0, 32'h44);

    // Trap out of halt into the top of the address space, then wrap.
    halt_i = 1; npc_op_i = OpHold;
    step();
    check("halt2", {31'd0, h1}, 32'd1);
    halt_i = 0; trap_i = 1; trap_vec_i = 32'hFFFF_FFFC;
    step();
    check("htrap_pc", pc1, 32'hFFFF_FFFC);
    check("htrap_run", {30'd0, fv1, h1}, 32'd2);
    trap_i = 0; npc_op_i = OpPc4;
    step();
    check("wrap0", pc0, 32'h0);
    check("wrap1", pc1, 32'h0);

    // Link PC.
    npc_op_i = OpHold; ex_pc_i = 32'h10; insn_len2_i = 1; wb_pc_sel_i = 0;
    #1;
    check("wb_len4", wb0, 32'h14);
    check("wb_len2", wb1, 32'h12);
    wb_pc_sel_i = 1; imm_i = 32'h20;
    #1;
    check("wb_imm", wb1, 32'h30);

    // Odd return address is misaligned in both modes; reset kills the pulse.
    npc_op_i = OpRet; epc_i = 32'h101;
    step();
    check("ret_mis", {30'd0, mis0, mis1}, 32'd3);
    check("ret_maddr", maddr1, 32'h101);
    check("ret_hold", pc1, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_mis", {30'd0, mis0, mis1}, 32'd0);
    check("mid_rst_maddr", maddr1, 32'd0);
    check("mid_rst_pc", pc1, RstPc);
    check("mid_rst_fv", {31'd0, fv1}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
